// File: rtl/bit_count_pkg.sv
// Shared types and constants for the sequential population counter.
// The result width is fixed; only the examined operand width is a parameter.
package bit_count_pkg;

   localparam int DEFAULT_WIDTH = 32;
   localparam int RESULT_W      = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/bit_count.sv
// Sequential population counter: captures a WIDTH-bit word on start, examines one
// bit per clock, and presents the count with a registered finish flag.
module bit_count
   import bit_count_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [WIDTH-1:0]    in,
   output logic                finish,
   output logic [RESULT_W-1:0] bitcount
);

   // A 1-bit operand still needs a 1-bit index register.
   localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

   state_t               r_state;
   logic [WIDTH-1:0]     r_shreg;
   logic [IDX_W-1:0]     r_idx;
   logic [RESULT_W-1:0]  r_acc;
   logic                 r_finish;
   logic [RESULT_W-1:0]  r_bitcount;

   state_t               w_next_state;
   logic                 w_accept;
   logic                 w_last;
   logic [RESULT_W-1:0]  w_acc_next;

   assign w_acc_next = r_acc + {{(RESULT_W-1){1'b0}}, r_shreg[0]};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // start is only honoured when no operation is in flight.
   always_comb begin
      w_next_state = r_state;
      w_accept     = 1'b0;
      w_last       = 1'b0;
      case (r_state)
         IDLE, DONE: begin
            if (start) begin
               w_accept     = 1'b1;
               w_next_state = BUSY;
            end
         end
         BUSY: begin
            if (r_idx == LAST_IDX) begin
               w_last       = 1'b1;
               w_next_state = DONE;
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_shreg    <= '0;
         r_idx      <= '0;
         r_acc      <= '0;
         r_finish   <= 1'b0;
         r_bitcount <= '0;
      end else if (w_accept) begin
         r_shreg  <= in;
         r_idx    <= '0;
         r_acc    <= '0;
         r_finish <= 1'b0;
      end else if (r_state == BUSY) begin
         r_shreg <= r_shreg >> 1;
         r_idx   <= r_idx + IDX_ONE;
         r_acc   <= w_acc_next;
         // Output only updates with the complete sum, never partial counts.
         if (w_last) begin
            r_bitcount <= w_acc_next;
            r_finish   <= 1'b1;
         end
      end
   end

   assign finish   = r_finish;
   assign bitcount = r_bitcount;

endmodule

// File: tb/tb_bit_count.sv
// Directed bench for bit_count (WIDTH=32): reset, vectors, latency, isolation,
// restart, abort and back-to-back operation.
module tb_bit_count;

   logic        clk;
   logic        rst;
   logic        start;
   logic [31:0] in;
   logic        finish;
   logic [31:0] bitcount;

   int vectors    = 0;
   int miscompares = 0;

   bit_count #(.WIDTH(32)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .in       (in),
      .finish   (finish),
      .bitcount (bitcount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Two-cycle start pulse; optionally scramble the operand after capture and
   // fire a stray start pulse mid-operation.
   task automatic do_op(input logic [31:0] val, input logic [31:0] exp,
                        input logic [31:0] prev, input bit wiggle, input bit midpulse);
      int k;
      @(negedge clk);
      start = 1'b1;
      in    = val;
      @(negedge clk);
      chk("finish_low_after_capture", {31'b0, finish}, 32'd0);
      chk("bitcount_hold_after_capture", bitcount, prev);
      k = 0;
      while (k < 40) begin
         @(negedge clk);
         k++;
         if (k == 1) start = 1'b0;
         if (wiggle) in = $urandom;
         if (midpulse) begin
            start = (k == 10 || k == 11);
            if (k == 10) in = ~val;
         end
         if (k == 16) chk("bitcount_hold_busy", bitcount, prev);
         if (finish) break;
      end
      start = 1'b0;
      chk("latency", k, 32);
      chk("result", bitcount, exp);
   endtask

   initial begin
      int highs;
      rst   = 1'b0;
      start = 1'b0;
      in    = '0;

      #12;
      chk("reset_finish", {31'b0, finish}, 32'd0);
      chk("reset_bitcount", bitcount, 32'd0);
      @(negedge clk);
      rst = 1'b1;

      highs = 0;
      repeat (6) begin
         @(negedge clk);
         if (finish) highs++;
      end
      chk("idle_hold_no_finish", highs, 0);
      chk("idle_hold_bitcount", bitcount, 32'd0);

      do_op(32'h0000_0000, 32'd0,  32'd0,  1'b0, 1'b0);
      do_op(32'h8000_0000, 32'd1,  32'd0,  1'b0, 1'b0);
      do_op(32'h8000_0800, 32'd2,  32'd1,  1'b0, 1'b0);
      do_op(32'h8408_0804, 32'd5,  32'd2,  1'b0, 1'b0);

      // DONE holds finish and result while start stays low.
      repeat (5) @(negedge clk);
      chk("done_hold_finish", {31'b0, finish}, 32'd1);
      chk("done_hold_bitcount", bitcount, 32'd5);

      do_op(32'h9010_C83C, 32'd10, 32'd5,  1'b1, 1'b0);
      do_op(32'hF852_4A22, 32'd13, 32'd10, 1'b0, 1'b1);
      do_op(32'hFF00_FF00, 32'd16, 32'd13, 1'b1, 1'b0);
      do_op(32'h00FF_00FF, 32'd16, 32'd16, 1'b0, 1'b0);
      do_op(32'hFFFF_FFFF, 32'd32, 32'd16, 1'b0, 1'b0);

      // Abort mid-BUSY: asynchronous clear, then no finish afterwards.
      @(negedge clk);
      start = 1'b1;
      in    = 32'h0F0F_0F0F;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("abort_finish", {31'b0, finish}, 32'd0);
      chk("abort_bitcount", bitcount, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      highs = 0;
      repeat (40) begin
         @(negedge clk);
         if (finish) highs++;
      end
      chk("abort_no_finish", highs, 0);

      // Continuous start: one-cycle finish pulses 33 edges apart.
      @(negedge clk);
      start = 1'b1;
      in    = 32'hFF00_FF00;
      highs = 0;
      for (int i = 0; i < 70; i++) begin
         @(negedge clk);
         if (finish) begin
            highs++;
            chk("b2b_pulse_pos", i, (highs == 1) ? 32 : 65);
         end
      end
      start = 1'b0;
      chk("b2b_pulse_count", highs, 2);
      chk("b2b_result", bitcount, 32'd16);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
